// File: rtl/filter_pkg.sv
// Shared types, constants and helpers for the time-multiplexed deglitch engine.
package filter_pkg;

    localparam int SYNC_STAGES  = 2;
    localparam int MAX_CHANNELS = 16;
    localparam int MAX_STAGES   = 16;
    localparam int DEPTH_ARG_W  = 5;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scanState_t;

    // Agreement mask: the low 'depth' bits set, everything above cleared.
    function automatic logic [MAX_STAGES-1:0] depthMask(input logic [DEPTH_ARG_W-1:0] depth);
        logic [MAX_STAGES-1:0] mask;
        mask = {MAX_STAGES{1'b0}};
        for (int i = 0; i < MAX_STAGES; i++) begin
            mask[i] = (i < int'(depth)) ? 1'b1 : 1'b0;
        end
        return mask;
    endfunction

endpackage

// File: rtl/filter_sched_if.sv
// Control/status bundle between the mode logic (master) and the deglitch engine (slave).
interface filter_sched_if #(
    parameter int CHANNELS   = 4,
    parameter int STAGES     = 8,
    parameter int PRESCALE_W = 8
);

    logic                             EnableIn;
    logic [PRESCALE_W-1:0]            PrescaleIn;
    logic [$clog2(STAGES + 1)-1:0]    DepthIn;
    logic [CHANNELS-1:0]              SignalIn;
    logic [CHANNELS-1:0]              SignalOut;
    logic [CHANNELS-1:0]              EdgeOut;
    logic                             OverrunOut;

    modport master (
        output EnableIn, PrescaleIn, DepthIn, SignalIn,
        input  SignalOut, EdgeOut, OverrunOut
    );

    modport slave (
        input  EnableIn, PrescaleIn, DepthIn, SignalIn,
        output SignalOut, EdgeOut, OverrunOut
    );

endinterface

// File: rtl/filter_prescaler.sv
// Sample-tick generator: one-cycle registered tick every PrescaleIn+1 enabled cycles.
module filter_prescaler #(
    parameter int PRESCALE_W = 8
) (
    input  logic                  ClkIn,
    input  logic                  nRstIn,
    input  logic                  EnableIn,
    input  logic [PRESCALE_W-1:0] PrescaleIn,
    output logic                  TickOut
);

    logic [PRESCALE_W-1:0] count_r;
    logic                  tick_r;

    // Count while enabled; >= compare so a lowered period never runs past terminal count.
    always_ff @(posedge ClkIn) begin
        if (!nRstIn) begin
            count_r <= {PRESCALE_W{1'b0}};
            tick_r  <= 1'b0;
        end else if (!EnableIn) begin
            count_r <= {PRESCALE_W{1'b0}};
            tick_r  <= 1'b0;
        end else if (count_r >= PrescaleIn) begin
            count_r <= {PRESCALE_W{1'b0}};
            tick_r  <= 1'b1;
        end else begin
            count_r <= count_r + {{(PRESCALE_W-1){1'b0}}, 1'b1};
            tick_r  <= 1'b0;
        end
    end

    assign TickOut = tick_r;

endmodule

// File: rtl/filter_sched.sv
// Time-multiplexed deglitch engine: one shared evaluator walks all channels per tick.
module filter_sched
    import filter_pkg::*;
#(
    parameter int CHANNELS   = 4,
    parameter int STAGES     = 8,
    parameter int PRESCALE_W = 8
) (
    input  logic           ClkIn,
    input  logic           nRstIn,
    filter_sched_if.slave  bus
);

    localparam int DEPTH_W = $clog2(STAGES + 1);
    localparam int CHAN_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [CHAN_W-1:0]  LAST_CHAN  = CHAN_W'(CHANNELS - 1);
    localparam logic [DEPTH_W-1:0] FULL_DEPTH = DEPTH_W'(STAGES);

    logic [CHANNELS-1:0]   sync_r [SYNC_STAGES];
    logic [STAGES-1:0]     history_r [CHANNELS];
    logic [CHANNELS-1:0]   signal_r;
    logic [CHANNELS-1:0]   edge_r;
    logic                  overrun_r;

    scanState_t            state_r, nextState_s;
    logic [CHAN_W-1:0]     chan_r, nextChan_s;
    logic [DEPTH_W-1:0]    depth_r, nextDepth_s, effDepth_s;

    logic                  tick_s;
    logic                  scanActive_s;
    logic                  overrunSet_s;
    logic [STAGES-1:0]     hNext_s;
    logic [MAX_STAGES-1:0] hWide_s;
    logic [MAX_STAGES-1:0] mask_s;
    logic [MAX_STAGES-1:0] hMasked_s;
    logic                  newLevel_s;

    filter_prescaler #(.PRESCALE_W(PRESCALE_W)) prescaler (
        .ClkIn      (ClkIn),
        .nRstIn     (nRstIn),
        .EnableIn   (bus.EnableIn),
        .PrescaleIn (bus.PrescaleIn),
        .TickOut    (tick_s)
    );

    // Two-flop synchronizer chain on the raw pins; runs regardless of EnableIn.
    always_ff @(posedge ClkIn) begin
        if (!nRstIn) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= {CHANNELS{1'b0}};
        end else begin
            sync_r[0] <= bus.SignalIn;
            for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
        end
    end

    // Out-of-range depth (0 or beyond the history length) means full history.
    always_comb begin
        effDepth_s = FULL_DEPTH;
        if ((bus.DepthIn == {DEPTH_W{1'b0}}) || (bus.DepthIn > FULL_DEPTH)) begin
            effDepth_s = FULL_DEPTH;
        end else begin
            effDepth_s = bus.DepthIn;
        end
    end

    // Sequencer state register.
    always_ff @(posedge ClkIn) begin
        if (!nRstIn) begin
            state_r <= IDLE;
            chan_r  <= {CHAN_W{1'b0}};
            depth_r <= FULL_DEPTH;
        end else begin
            state_r <= nextState_s;
            chan_r  <= nextChan_s;
            depth_r <= nextDepth_s;
        end
    end

    // Sequencer next state: depth is latched once per scan; ticks during a scan are dropped.
    always_comb begin
        nextState_s  = state_r;
        nextChan_s   = chan_r;
        nextDepth_s  = depth_r;
        scanActive_s = 1'b0;
        overrunSet_s = 1'b0;
        if (!bus.EnableIn) begin
            nextState_s = IDLE;
            nextChan_s  = {CHAN_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (tick_s) begin
                        nextState_s = SCAN;
                        nextChan_s  = {CHAN_W{1'b0}};
                        nextDepth_s = effDepth_s;
                    end else begin
                        nextState_s = IDLE;
                    end
                end
                SCAN: begin
                    scanActive_s = 1'b1;
                    overrunSet_s = tick_s;
                    if (chan_r == LAST_CHAN) begin
                        nextState_s = IDLE;
                        nextChan_s  = {CHAN_W{1'b0}};
                    end else begin
                        nextChan_s  = chan_r + {{(CHAN_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    nextState_s = IDLE;
                    nextChan_s  = {CHAN_W{1'b0}};
                end
            endcase
        end
    end

    // Shared evaluator for the channel currently selected by the sequencer.
    always_comb begin
        hNext_s   = {history_r[chan_r][STAGES-2:0], sync_r[SYNC_STAGES-1][chan_r]};
        hWide_s   = MAX_STAGES'(hNext_s);
        mask_s    = depthMask(DEPTH_ARG_W'(depth_r));
        hMasked_s = hWide_s & mask_s;
        if (hMasked_s == mask_s) begin
            newLevel_s = 1'b1;
        end else if (hMasked_s == {MAX_STAGES{1'b0}}) begin
            newLevel_s = 1'b0;
        end else begin
            newLevel_s = signal_r[chan_r];
        end
    end

    // History, filtered level, edge pulse and sticky overrun updates.
    always_ff @(posedge ClkIn) begin
        if (!nRstIn) begin
            for (int k = 0; k < CHANNELS; k++) history_r[k] <= {STAGES{1'b0}};
            signal_r  <= {CHANNELS{1'b0}};
            edge_r    <= {CHANNELS{1'b0}};
            overrun_r <= 1'b0;
        end else begin
            edge_r <= {CHANNELS{1'b0}};
            if (scanActive_s) begin
                history_r[chan_r] <= hNext_s;
                signal_r[chan_r]  <= newLevel_s;
                edge_r[chan_r]    <= newLevel_s ^ signal_r[chan_r];
            end
            if (overrunSet_s) begin
                overrun_r <= 1'b1;
            end
        end
    end

    assign bus.SignalOut  = signal_r;
    assign bus.EdgeOut    = edge_r;
    assign bus.OverrunOut = overrun_r;

endmodule

// File: tb/tb_filter_sched.sv
// Scoreboard bench for filter_sched: directed stimulus pushes expected edge events,
// a negedge monitor pops and compares every EdgeOut event with its cycle stamp.
module tb_filter_sched;

    localparam int CH = 4;
    localparam int ST = 8;
    localparam int PW = 8;

    typedef struct {
        int         cyc;
        logic [3:0] edg;
        logic [3:0] sig;
    } exp_t;

    logic ClkIn = 1'b0;
    logic nRstIn;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    int   a;
    int   b;
    exp_t expQ[$];

    filter_sched_if #(.CHANNELS(CH), .STAGES(ST), .PRESCALE_W(PW)) bus ();

    filter_sched #(.CHANNELS(CH), .STAGES(ST), .PRESCALE_W(PW)) dut (
        .ClkIn  (ClkIn),
        .nRstIn (nRstIn),
        .bus    (bus)
    );

    always #5 ClkIn = ~ClkIn;

    always @(posedge ClkIn) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) @(posedge ClkIn);
        #1;
    endtask

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %0h required %0h", name, act, req);
        end
    endtask

    task automatic push(input int c, input logic [3:0] e, input logic [3:0] s);
        exp_t x;
        x.cyc = c;
        x.edg = e;
        x.sig = s;
        expQ.push_back(x);
    endtask

    task automatic drain(input string name);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL %s missing_events got %0d required 0", name, expQ.size());
        end
        expQ.delete();
    endtask

    task automatic doReset(input logic [3:0] sig, input logic [3:0] depth, input logic [7:0] pre);
        bus.EnableIn   = 1'b0;
        bus.SignalIn   = sig;
        bus.DepthIn    = depth;
        bus.PrescaleIn = pre;
        nRstIn         = 1'b0;
        step(3);
        nRstIn = 1'b1;
        step(4);
    endtask

    // Monitor: every cycle with an edge pulse must match the next expected event.
    initial begin
        exp_t e;
        forever begin
            @(negedge ClkIn);
            if (nRstIn === 1'b1 && bus.EdgeOut !== 4'b0000) begin
                checks++;
                if (expQ.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_edge got cyc=%0d edge=%b sig=%b required no_edge",
                             cyc, bus.EdgeOut, bus.SignalOut);
                end else begin
                    e = expQ.pop_front();
                    if (e.cyc != cyc || e.edg !== bus.EdgeOut || e.sig !== bus.SignalOut) begin
                        errors++;
                        $display("FAIL edge_event got cyc=%0d edge=%b sig=%b required cyc=%0d edge=%b sig=%b",
                                 cyc, bus.EdgeOut, bus.SignalOut, e.cyc, e.edg, e.sig);
                    end
                end
            end
        end
    end

    initial begin
        // Reset with all inputs high, then first-tick timing with depth 1.
        bus.EnableIn   = 1'b0;
        bus.SignalIn   = 4'hF;
        bus.DepthIn    = 4'd1;
        bus.PrescaleIn = 8'd9;
        nRstIn         = 1'b0;
        step(3);
        checkVal("reset_signal", 32'(bus.SignalOut), 32'h0);
        checkVal("reset_edge", 32'(bus.EdgeOut), 32'h0);
        checkVal("reset_overrun", 32'(bus.OverrunOut), 32'h0);
        nRstIn = 1'b1;
        step(4);
        a = cyc;
        bus.EnableIn = 1'b1;
        push(a + 12, 4'b0001, 4'b0001);
        push(a + 13, 4'b0010, 4'b0011);
        push(a + 14, 4'b0100, 4'b0111);
        push(a + 15, 4'b1000, 4'b1111);
        step(40);
        checkVal("first_tick_level", 32'(bus.SignalOut), 32'hF);
        drain("first_tick");

        // Step on channel 2, depth 4: rises 4 cycles after the 4th tick.
        doReset(4'h0, 4'd4, 8'd9);
        a = cyc;
        bus.EnableIn = 1'b1;
        bus.SignalIn = 4'b0100;
        push(a + 44, 4'b0100, 4'b0100);
        step(60);
        checkVal("step_level", 32'(bus.SignalOut), 32'h4);
        checkVal("step_no_overrun", 32'(bus.OverrunOut), 32'h0);
        drain("step");

        // Three-sample glitch against depth 4: rejected.
        doReset(4'h0, 4'd4, 8'd9);
        a = cyc;
        bus.EnableIn = 1'b1;
        bus.SignalIn = 4'b0001;
        step(30);
        bus.SignalIn = 4'b0000;
        step(50);
        checkVal("glitch_d4_level", 32'(bus.SignalOut), 32'h0);
        drain("glitch_d4");

        // Same pulse against depth 3: rises on 3rd tick, falls after 3 low samples.
        doReset(4'h0, 4'd3, 8'd9);
        a = cyc;
        bus.EnableIn = 1'b1;
        bus.SignalIn = 4'b0001;
        push(a + 32, 4'b0001, 4'b0001);
        push(a + 62, 4'b0001, 4'b0000);
        step(30);
        bus.SignalIn = 4'b0000;
        step(50);
        checkVal("glitch_d3_level", 32'(bus.SignalOut), 32'h0);
        drain("glitch_d3");

        // Depth 0, 15 and 8 all need 8 agreeing samples on channel 1.
        for (int d = 0; d < 3; d++) begin
            logic [3:0] dv;
            dv = (d == 0) ? 4'd0 : ((d == 1) ? 4'd15 : 4'd8);
            doReset(4'h0, dv, 8'd9);
            a = cyc;
            bus.EnableIn = 1'b1;
            bus.SignalIn = 4'b0010;
            push(a + 83, 4'b0010, 4'b0010);
            step(90);
            checkVal("full_depth_level", 32'(bus.SignalOut), 32'h2);
            drain("full_depth");
        end

        // Depth 1 follows the synced input at every tick on channel 3.
        doReset(4'h0, 4'd1, 8'd9);
        a = cyc;
        bus.EnableIn = 1'b1;
        bus.SignalIn = 4'b1000;
        push(a + 15, 4'b1000, 4'b1000);
        push(a + 25, 4'b1000, 4'b0000);
        push(a + 35, 4'b1000, 4'b1000);
        step(20);
        bus.SignalIn = 4'b0000;
        step(10);
        bus.SignalIn = 4'b1000;
        step(20);
        checkVal("depth1_level", 32'(bus.SignalOut), 32'h8);
        drain("depth1");

        // Overrun: period 3 with 4 channels; second tick lands mid-scan.
        doReset(4'hF, 4'd1, 8'd2);
        a = cyc;
        bus.EnableIn = 1'b1;
        push(a + 5, 4'b0001, 4'b0001);
        push(a + 6, 4'b0010, 4'b0011);
        push(a + 7, 4'b0100, 4'b0111);
        push(a + 8, 4'b1000, 4'b1111);
        step(6);
        checkVal("overrun_before", 32'(bus.OverrunOut), 32'h0);
        step(1);
        checkVal("overrun_set", 32'(bus.OverrunOut), 32'h1);
        step(30);
        checkVal("overrun_sticky", 32'(bus.OverrunOut), 32'h1);
        checkVal("overrun_level", 32'(bus.SignalOut), 32'hF);
        drain("overrun");

        // Enable dropped while channel 1 is in flight; scan restarts from channel 0.
        doReset(4'hF, 4'd1, 8'd9);
        a = cyc;
        bus.EnableIn = 1'b1;
        push(a + 12, 4'b0001, 4'b0001);
        step(12);
        bus.EnableIn = 1'b0;
        step(8);
        checkVal("disable_retained", 32'(bus.SignalOut), 32'h1);
        b = cyc;
        bus.EnableIn = 1'b1;
        push(b + 13, 4'b0010, 4'b0011);
        push(b + 14, 4'b0100, 4'b0111);
        push(b + 15, 4'b1000, 4'b1111);
        step(20);
        checkVal("reenable_level", 32'(bus.SignalOut), 32'hF);
        drain("reenable");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/filter_sched.md
# filter_sched

Time-multiplexed deglitch engine for the board's slow external inputs (buttons, mode straps, sync-presence lines). Instead of one free-running shift filter per pin on the pixel clock, a single sequencer samples all channels at a programmable tick rate, keeps a per-channel sample history, and applies the all-high / all-low agreement rule with a run-time depth. It sits between the pin synchronizers and the mode/control logic and reports clean levels plus one-cycle edge pulses.

## Interface
- CHANNELS, 4: number of input lines, 1..16
- STAGES, 8: history length per channel, 2..16
- PRESCALE_W, 8: width of prescaler compare value
- ClkIn  in  1  system clock, all logic on rising edge
- nRstIn  in  1  synchronous active-low reset
- EnableIn  in  1  1 = run sampling; 0 = hold
- PrescaleIn  in  PRESCALE_W  tick period minus 1, in ClkIn cycles
- DepthIn  in  $clog2(STAGES+1)  agreeing samples required; 0 or >STAGES treated as STAGES
- SignalIn  in  CHANNELS  raw asynchronous inputs
- SignalOut  out  CHANNELS  filtered levels
- EdgeOut  out  CHANNELS  one-cycle pulse when the matching SignalOut bit changes
- OverrunOut  out  1  sticky: a tick arrived while a scan was still running

## Operation
- Reset (nRstIn low at a rising edge): History all 0, SignalOut 0, EdgeOut 0, OverrunOut 0, prescaler 0, FSM IDLE, sync flops 0.
- Each SignalIn bit passes through a 2-flop synchronizer (always running, even when disabled).
- Prescaler: counts up while EnableIn=1; when count >= PrescaleIn, tick asserts for one cycle and count returns to 0. Compare is >= so lowering PrescaleIn mid-count never skips past the terminal count.
- FSM states:
  - IDLE: on tick, latch effective depth D, set Chan=0, go to SCAN.
  - SCAN: process channel Chan; if Chan==CHANNELS-1 go to IDLE, else Chan+1.
- Processing channel k: h' = {History[k][STAGES-2:0], Sync[k]}; mask m = low D bits set.
  - (h' & m) == m: SignalOut[k] <= 1.
  - (h' & m) == 0: SignalOut[k] <= 0.
  - Otherwise hold. History[k] <= h'.
- EdgeOut[k] is 1 only in the cycle after SignalOut[k] changes value, coincident with the new level.
- A tick while in SCAN sets OverrunOut and is dropped; the current scan completes normally. OverrunOut clears only on reset.
- EnableIn=0: prescaler forced to 0, no ticks, FSM forced to IDLE at the next edge (partial scan abandoned). History, SignalOut and OverrunOut are retained. EdgeOut goes to 0.
- D latched per scan: all channels in one scan use the same depth, even if DepthIn changes mid-scan.

## Timing
- Tick at cycle T. Channel k is processed in cycle T+1+k. SignalOut[k] and EdgeOut[k] are visible from T+2+k.
- Tick period is PrescaleIn+1 cycles. Overrun-free operation requires PrescaleIn+1 >= CHANNELS+1.
- Worst-case latency for a clean input step to reach SignalOut[k]: 2 sync cycles + D tick periods + (2+k) cycles.
- A glitch shorter than D consecutive samples never changes SignalOut.

## Structure
- Shared package `filter_pkg`:
  - FSM state enum (IDLE, SCAN).
  - Depth-to-mask function.
  - Constants SYNC_STAGES=2 and MAX_CHANNELS=16.
- One sub-module, `filter_prescaler`: counter, >= compare, enable clear, tick output.
- Per-channel history is a register array in `filter_sched`. The evaluate datapath is shared, not replicated per channel.

## Test plan
- Reset: assert nRstIn=0 with SignalIn=4'hF for 3 cycles -> SignalOut=0, EdgeOut=0, OverrunOut=0. First tick after release occurs PrescaleIn+1 cycles after enable.
- Step: PrescaleIn=9, DepthIn=4, ch2 driven 0->1 and held -> SignalOut[2] rises on the 4th tick after the sync delay, exactly 2+2 cycles after that tick. EdgeOut[2] is high for exactly 1 cycle. Other channels are unchanged.
- Glitch rejection: DepthIn=4, ch0 pulsed high for 3 tick periods then low -> SignalOut[0] stays 0 and no EdgeOut. Repeat with DepthIn=3 -> SignalOut[0] rises.
- Depth edge values: DepthIn=0 and DepthIn=15 (STAGES=8) behave identically to DepthIn=8. DepthIn=1 follows the synced input at every tick.
- Overrun: CHANNELS=4, PrescaleIn=2 -> OverrunOut sets on the second tick and stays set. Scans still complete in order 0..3.
- Enable mid-scan: drop EnableIn during the cycle channel 1 is processed -> channels 2..3 are not updated in that scan. Re-enable -> the scan restarts from channel 0 after a full tick period. SignalOut is retained throughout.
